// File: rtl/show_sequencer.sv
// Show controller: launches each pattern block in turn, routes its lights to the relays,
// inserts a dark gap between patterns, guards each pattern with a watchdog and optionally loops.
module show_sequencer #(
    parameter int NUM_PATTERNS = 4,
    parameter int CLKS_PER_MS  = 5000,
    parameter int GAP_MS       = 1000,
    parameter int TIMEOUT_MS   = 600000,
    localparam int IW = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      loop_en,
    input  logic [NUM_PATTERNS-1:0]   finished_in,
    input  logic [8*NUM_PATTERNS-1:0] pat_lights_in,
    output logic [NUM_PATTERNS-1:0]   go_out,
    output logic [7:0]                lights,
    output logic [IW-1:0]             cur_pattern,
    output logic                      busy,
    output logic                      show_done,
    output logic                      timeout_err
);

    // state  | meaning
    // IDLE   | dark, waiting for a fresh start edge
    // LAUNCH | one cycle; go to pattern idx is issued on the next edge
    // RUN    | pattern idx active, lights routed, watchdog counting
    // GAP    | dark interval before the next pattern or the end of the show
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, GAP} state_t;

    localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_MS - 1);
    localparam logic [19:0]   GAP_LAST   = 20'(GAP_MS - 1);
    localparam logic [19:0]   TO_LAST    = 20'(TIMEOUT_MS - 1);
    localparam logic [19:0]   MS_MAX     = '1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_PATTERNS - 1);

    state_t                  state;
    logic [IW-1:0]           idx;
    logic                    start_low_q;
    logic [PW-1:0]           presc;
    logic [19:0]             ms_cnt;

    logic                    tick;
    logic                    gap_hit;
    logic                    timeout_hit;
    logic                    start_edge;
    logic                    fin_sel;
    logic [7:0]              lights_sel;
    logic [NUM_PATTERNS-1:0] go_sel;

    // start_low_q resets to 0 ("not yet seen low"), so a start held through reset is not an edge
    assign start_edge  = start & start_low_q;
    assign tick        = (presc == PRESC_LAST);
    assign gap_hit     = tick && (ms_cnt == GAP_LAST);
    assign timeout_hit = tick && (ms_cnt == TO_LAST);
    assign cur_pattern = idx;

    always_comb begin
        fin_sel    = 1'b0;
        lights_sel = '0;
        go_sel     = '0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (idx == IW'(i)) begin
                fin_sel    = finished_in[i];
                lights_sel = pat_lights_in[8*i +: 8];
                go_sel[i]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            start_low_q <= 1'b0;
            presc       <= '0;
            ms_cnt      <= '0;
            go_out      <= '0;
            lights      <= '0;
            busy        <= 1'b0;
            show_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            start_low_q <= ~start;
            go_out      <= '0;
            lights      <= '0;
            show_done   <= 1'b0;

            if (tick) begin
                presc <= '0;
                if (ms_cnt != MS_MAX) ms_cnt <= ms_cnt + 20'd1;
            end else begin
                presc <= presc + PW'(1);
            end

            if (stop) begin
                state  <= IDLE;
                busy   <= 1'b0;
                presc  <= '0;
                ms_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        presc  <= '0;
                        ms_cnt <= '0;
                        if (start_edge) begin
                            idx         <= '0;
                            timeout_err <= 1'b0;
                            busy        <= 1'b1;
                            state       <= LAUNCH;
                        end
                    end
                    LAUNCH: begin
                        go_out <= go_sel;
                        presc  <= '0;
                        ms_cnt <= '0;
                        state  <= RUN;
                    end
                    RUN: begin
                        lights <= lights_sel;
                        // a finish in the same cycle as the watchdog expiry takes priority
                        if (fin_sel) begin
                            presc  <= '0;
                            ms_cnt <= '0;
                            state  <= GAP;
                        end else if (timeout_hit) begin
                            timeout_err <= 1'b1;
                            presc       <= '0;
                            ms_cnt      <= '0;
                            state       <= GAP;
                        end
                    end
                    GAP: begin
                        if (gap_hit) begin
                            if (idx != IDX_LAST) begin
                                idx   <= idx + IW'(1);
                                state <= LAUNCH;
                            end else if (loop_en) begin
                                idx   <= '0;
                                state <= LAUNCH;
                            end else begin
                                show_done <= 1'b1;
                                busy      <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_show_sequencer.sv
// Scoreboard bench for show_sequencer: expected go/done events are queued when stimulus is
// driven and compared when the DUT emits them; lights are compared every cycle.
module tb_show_sequencer;
    localparam int NP      = 3;
    localparam int CPM     = 4;
    localparam int GAP     = 2;
    localparam int TO      = 50;
    localparam int GAP_CYC = GAP * CPM;
    localparam int TO_CYC  = TO * CPM;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            loop_en = 1'b0;
    logic [NP-1:0]   finished_in = '0;
    logic [8*NP-1:0] pat_lights_in = '0;
    logic [NP-1:0]   go_out;
    logic [7:0]      lights;
    logic [1:0]      cur_pattern;
    logic            busy;
    logic            show_done;
    logic            timeout_err;

    show_sequencer #(
        .NUM_PATTERNS(NP), .CLKS_PER_MS(CPM), .GAP_MS(GAP), .TIMEOUT_MS(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
        .finished_in(finished_in), .pat_lights_in(pat_lights_in), .go_out(go_out),
        .lights(lights), .cur_pattern(cur_pattern), .busy(busy), .show_done(show_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_done;
        logic [NP-1:0] go;
        int            at;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         go_count = 0;
    int         done_count = 0;
    int         fin_delay[NP];
    int         cnt[NP];
    logic [7:0] pat_val[NP];
    bit         run_v = 1'b0;
    int         run_i = 0;
    int         run_age = 0;
    logic [NP-1:0] stray = '0;

    task automatic set_pats(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2);
        pat_val[0] = p0;
        pat_val[1] = p1;
        pat_val[2] = p2;
        pat_lights_in = {p2, p1, p0};
    endtask

    task automatic reset_model();
        exp_q.delete();
        run_v = 1'b0;
        stray = '0;
        finished_in = '0;
        for (int i = 0; i < NP; i++) cnt[i] = 0;
    endtask

    task automatic push_go(input int k, input int at);
        exp_t e;
        e.is_done = 1'b0;
        e.go = NP'(1) << k;
        e.at = at;
        exp_q.push_back(e);
    endtask

    // one clock: check outputs, advance the bench's RUN model and the pattern models
    task automatic cycle();
        bit stop_s, fin_s;
        logic [7:0] exp_l;
        logic [NP-1:0] fire;
        exp_t e;
        stop_s = stop;
        fin_s = run_v && finished_in[run_i];
        @(negedge clk);
        cyc++;
        exp_l = (run_v && !stop_s) ? pat_val[run_i] : 8'h00;
        checks++;
        if (lights !== exp_l) begin
            failures++;
            $display("FAIL lights cyc=%0d got=%h exp=%h", cyc, lights, exp_l);
        end
        if (run_v) begin
            if (fin_s || stop_s || run_age == TO_CYC - 1) run_v = 1'b0;
            else run_age++;
        end
        if (go_out !== '0 || show_done !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event cyc=%0d go=%b done=%b", cyc, go_out, show_done);
            end else begin
                e = exp_q.pop_front();
                if (go_out !== e.go || show_done !== e.is_done || cyc != e.at) begin
                    failures++;
                    $display("FAIL event cyc=%0d go=%b done=%b exp_cyc=%0d exp_go=%b exp_done=%b",
                             cyc, go_out, show_done, e.at, e.go, e.is_done);
                end
                if (!e.is_done) begin
                    go_count++;
                    for (int i = 0; i < NP; i++) if (e.go[i]) run_i = i;
                    run_v = 1'b1;
                    run_age = 0;
                    checks++;
                    if (cur_pattern !== 2'(run_i)) begin
                        failures++;
                        $display("FAIL cur_pattern cyc=%0d got=%0d exp=%0d", cyc, cur_pattern, run_i);
                    end
                end else begin
                    done_count++;
                    checks++;
                    if (busy !== 1'b0) begin
                        failures++;
                        $display("FAIL busy_at_done cyc=%0d got=%b exp=0", cyc, busy);
                    end
                end
            end
        end
        fire = '0;
        for (int i = 0; i < NP; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) fire[i] = 1'b1;
            end
            if (go_out[i] && fin_delay[i] > 0) cnt[i] = fin_delay[i];
        end
        finished_in = fire | stray;
        stray = '0;
        if (run_v && fire[run_i]) begin
            if (run_i < NP - 1) push_go(run_i + 1, cyc + GAP_CYC + 2);
            else if (loop_en) push_go(0, cyc + GAP_CYC + 2);
            else begin
                e.is_done = 1'b1;
                e.go = '0;
                e.at = cyc + GAP_CYC + 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_go(input int target, input int limit);
        int n;
        n = 0;
        while (go_count < target && n < limit) begin
            cycle();
            n++;
        end
        if (go_count < target) begin
            checks++;
            failures++;
            $display("FAIL go_wait got=%0d exp=%0d", go_count, target);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int n;
        n = 0;
        while (done_count < target && n < limit) begin
            cycle();
            n++;
        end
        if (done_count < target) begin
            checks++;
            failures++;
            $display("FAIL done_wait got=%0d exp=%0d", done_count, target);
        end
    endtask

    task automatic launch_show();
        start = 1'b1;
        push_go(0, cyc + 2);
        cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        set_pats(8'h00, 8'h00, 8'h00);
        for (int i = 0; i < NP; i++) fin_delay[i] = 30;
        reset_model();
        repeat (3) @(negedge clk);
        checks++;
        if ({go_out, lights, cur_pattern, busy, show_done, timeout_err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {go_out, lights, cur_pattern, busy, show_done, timeout_err});
        end
        rst_n = 1'b1;
        repeat (3) cycle();
        checks++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b terr=%b exp=0", busy, timeout_err);
        end
    endtask

    task automatic test_basic_show();
        int base_go, base_done;
        set_pats(8'hFF, 8'hA5, 8'hFF);
        for (int i = 0; i < NP; i++) fin_delay[i] = 30;
        loop_en = 1'b0;
        reset_model();
        base_go = go_count;
        base_done = done_count;
        launch_show();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start got=%b exp=1", busy);
        end
        wait_go(base_go + 2, 200);
        repeat (3) cycle();
        checks++;
        if (lights !== 8'hA5) begin
            failures++;
            $display("FAIL routing_p1 got=%h exp=a5", lights);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_done(base_done + 1, 400);
        repeat (5) cycle();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_end busy=%b pending=%0d exp=0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_watchdog();
        int r, base_go, base_done;
        set_pats(8'h3C, 8'h81, 8'h7E);
        fin_delay[0] = 0;
        fin_delay[1] = 30;
        fin_delay[2] = 30;
        loop_en = 1'b0;
        reset_model();
        base_done = done_count;
        r = cyc + 2;
        push_go(1, r + TO_CYC + GAP_CYC + 1);
        launch_show();
        exp_q.push_front(exp_q.pop_back());
        while (cyc < r + TO_CYC) begin
            cycle();
            if (cyc == r + TO_CYC - 1) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_early cyc=%0d got=%b exp=0", cyc, timeout_err);
                end
            end
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_set cyc=%0d got=%b exp=1", cyc, timeout_err);
        end
        wait_done(base_done + 1, 600);
        repeat (4) cycle();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_held terr=%b busy=%b exp=1/0", timeout_err, busy);
        end
        fin_delay[0] = TO_CYC - 1;
        reset_model();
        base_go = go_count;
        r = cyc + 2;
        launch_show();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_cleared_by_start got=%b exp=0", timeout_err);
        end
        while (cyc < r + TO_CYC + 2) cycle();
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL finish_beats_timeout got=%b exp=0", timeout_err);
        end
        wait_go(base_go + 2, 100);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (40) cycle();
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL watchdog_end pending=%0d busy=%b exp=0/0", exp_q.size(), busy);
        end
    endtask

    task automatic test_loop();
        int base_go, base_done;
        set_pats(8'h01, 8'h02, 8'h04);
        for (int i = 0; i < NP; i++) fin_delay[i] = 20;
        loop_en = 1'b1;
        reset_model();
        base_go = go_count;
        base_done = done_count;
        start = 1'b1;
        push_go(0, cyc + 2);
        cycle();
        wait_go(base_go + 4, 500);
        checks++;
        if (done_count != base_done) begin
            failures++;
            $display("FAIL loop_no_done got=%0d exp=%0d", done_count, base_done);
        end
        loop_en = 1'b0;
        wait_done(base_done + 1, 500);
        repeat (20) cycle();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL loop_end_held_start busy=%b pending=%0d exp=0/0", busy, exp_q.size());
        end
        start = 1'b0;
        cycle();
    endtask

    task automatic test_stop_stray();
        int base_go;
        set_pats(8'h0F, 8'hF0, 8'h55);
        fin_delay[0] = 30;
        fin_delay[1] = 100;
        fin_delay[2] = 30;
        loop_en = 1'b0;
        reset_model();
        base_go = go_count;
        launch_show();
        repeat (10) cycle();
        stray = 3'b100;
        cycle();
        wait_go(base_go + 2, 200);
        repeat (40) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || lights !== 8'h00) begin
            failures++;
            $display("FAIL stop_to_idle busy=%b lights=%h exp=0/00", busy, lights);
        end
        repeat (80) cycle();
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL late_finish_ignored busy=%b pending=%0d exp=0/0", busy, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_show();
        int base_go;
        set_pats(8'hC3, 8'h99, 8'h66);
        for (int i = 0; i < NP; i++) fin_delay[i] = 30;
        loop_en = 1'b0;
        reset_model();
        base_go = go_count;
        launch_show();
        wait_go(base_go + 2, 200);
        repeat (35) cycle();
        #2;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        checks++;
        if ({go_out, lights, cur_pattern, busy, show_done, timeout_err} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0",
                     {go_out, lights, cur_pattern, busy, show_done, timeout_err});
        end
        reset_model();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (20) cycle();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL held_start_no_launch busy=%b exp=0", busy);
        end
        start = 1'b0;
        cycle();
        base_go = go_count;
        launch_show();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL fresh_edge_launch busy=%b exp=1", busy);
        end
        wait_go(base_go + 1, 20);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (40) cycle();
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_test_end pending=%0d busy=%b exp=0/0", exp_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_show();
        test_watchdog();
        test_loop();
        test_stop_stray();
        test_reset_mid_show();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/show_sequencer.md
# show_sequencer

Top-level show controller that sits directly upstream of the pattern blocks: it launches each pattern in turn with a one-cycle `go` pulse, waits for that pattern's `finished` pulse, and routes the active pattern's eight light outputs to the relay pins. Patterns are separated by a dark gap, guarded by a per-pattern watchdog, and the show optionally loops.

## Interface
- `NUM_PATTERNS`, 4: number of pattern blocks attached; index width is `IW = $clog2(NUM_PATTERNS)`, minimum 1.
- `CLKS_PER_MS`, 5000: clock cycles per millisecond tick.
- `GAP_MS`, 1000: dark time between patterns, in ms; ≥1.
- `TIMEOUT_MS`, 600000: watchdog limit per pattern, in ms; < 2^20.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  synchronous, pre-debounced show request; the rising edge is what counts.
- `stop`  in  1  synchronous abort, level.
- `loop_en`  in  1  restart from pattern 0 after the last pattern.
- `finished_in`  in  NUM_PATTERNS  per-pattern one-cycle completion pulses.
- `pat_lights_in`  in  8*NUM_PATTERNS  pattern i lights at bits [8i+7:8i], with bit 0 = light1.
- `go_out`  out  NUM_PATTERNS  one-hot, one-cycle launch pulse to pattern i.
- `lights`  out  8  relay drive; bit 0 = light1.
- `cur_pattern`  out  IW  index of the active or most recent pattern.
- `busy`  out  1  high whenever the state is not IDLE.
- `show_done`  out  1  one-cycle pulse when a non-looping show completes.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- States: IDLE, LAUNCH, RUN, GAP.
- IDLE
  - `lights` = 0.
  - A start rising edge (`start & ~start_q`) sets idx = 0 and moves to LAUNCH.
  - Clears `timeout_err`.
- LAUNCH
  - Lasts exactly one cycle.
  - `go_out[idx]` is asserted on the next cycle, registered.
  - Clears the prescaler and ms counter, then moves to RUN.
- RUN
  - `lights` = `pat_lights_in[8*idx +: 8]`.
  - `finished_in[idx]` moves to GAP.
  - `finished_in[j]` with j≠idx is ignored.
  - If the ms counter reaches TIMEOUT_MS before finish: set `timeout_err` and move to GAP.
  - If finish and timeout occur in the same cycle, finish wins and `timeout_err` is not set.
- GAP
  - `lights` = 0.
  - Entry clears the prescaler and ms counter.
  - When the ms counter reaches GAP_MS:
    - if idx < NUM_PATTERNS-1: idx+1, then LAUNCH;
    - else if `loop_en`: idx = 0, then LAUNCH;
    - else: pulse `show_done`, then IDLE.
  - `loop_en` is sampled only at this decision.
- `stop` high in any state forces IDLE on the next edge.
  - It overrides start, finish and timeout.
  - No `go_out` is issued in that cycle.
  - `lights` go to 0.
  - A pattern already running continues internally and is masked.
  - Its later `finished_in` is ignored in IDLE.
- Start edges while busy are ignored.
- `start` held high across a return to IDLE does not relaunch; a fresh edge is needed.
- Prescaler: 0..CLKS_PER_MS-1, tick on the terminal count, then wraps.
- ms counter: 20 bits, increments on tick, saturates (never wraps).

## Timing
- All outputs are registered.
- Reset value is 0 for every output and internal register; state resets to IDLE.
- Start edge at cycle n sets `busy` = 1 and LAUNCH at n+1, then `go_out[0]` = 1 at n+2 for exactly one cycle.
- `lights` follow `pat_lights_in` with one-cycle latency while in RUN.
- `finished_in` at cycle m sets GAP at m+1, with `lights` = 0 from m+2.
- GAP length: the next LAUNCH occurs exactly GAP_MS*CLKS_PER_MS cycles after GAP entry.
- `go_out` of the following pattern is asserted one cycle after LAUNCH.
- `show_done` and `busy` falling occur in the same cycle.
- Reset mid-show: all outputs go to 0 immediately (asynchronous), with no `go_out` glitch.

## Test plan
Parameters for all scenarios: NUM_PATTERNS=3, CLKS_PER_MS=4, GAP_MS=2, TIMEOUT_MS=50.

- Basic show: start pulse, each pattern model finishes 30 cycles after `go`, `loop_en` = 0.
  - `go_out` sequence 001, 010, 100, each one cycle.
  - Each gap is 8 cycles with `lights` = 0.
  - `show_done` pulses once, then `busy` = 0.
- Light routing: pattern1 drives 8'hA5 and the others drive 8'hFF.
  - During pattern1's RUN, `lights` = 8'hA5 with one-cycle lag.
  - In IDLE and GAP, `lights` = 0.
- Watchdog: pattern0 never finishes.
  - `timeout_err` = 1 after 200 cycles in RUN.
  - Pattern1 is still launched after the gap.
  - Flag is held until the next IDLE start.
  - Finish and timeout in the same cycle: no error is set.
- Loop: `loop_en` = 1 through pattern2's gap.
  - `go_out[0]` fires again and no `show_done`.
  - Dropping `loop_en` before the next end-of-gap decision makes the show end normally.
- Stop and stray finish: `stop` mid-RUN of pattern1.
  - IDLE next cycle with `lights` = 0.
  - A later `finished_in[1]` causes no transition.
  - `finished_in[2]` pulsed during pattern0's RUN is ignored.
- Reset and start edge: `rst_n` low mid-GAP clears all outputs asynchronously.
  - `start` held high through reset release causes no launch.
  - A new 0→1 edge launches pattern0.
